// File: rtl/modsq_iter_ctrl.sv
// Run controller for the modular squaring unit wrapper.
// Holds the MSU in reset between runs, sequences reset release and the
// start pulse, counts valid pulses up to a target, captures the output at
// the target iteration, and supervises the run with abort and a watchdog.
module modsq_iter_ctrl #(
    parameter int MOD_LEN            = 1024,
    parameter int WORD_LEN           = 16,
    parameter int REDUNDANT_ELEMENTS = 2,
    parameter int NUM_ELEMENTS       = MOD_LEN / WORD_LEN + REDUNDANT_ELEMENTS,
    parameter int SQ_OUT_BITS        = NUM_ELEMENTS * WORD_LEN * 2,
    parameter int ITER_W             = 64,
    parameter int RST_CYCLES         = 16,
    parameter int LAUNCH_CYCLES      = 16,
    parameter int WDOG_CYCLES        = 4096
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_start,
    input  logic [MOD_LEN-1:0]     cmd_sq_in,
    input  logic [ITER_W-1:0]      cmd_iters,
    input  logic                   cmd_abort,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [ITER_W-1:0]      iter_count,
    output logic [SQ_OUT_BITS-1:0] result,
    output logic                   result_valid,
    output logic                   msu_reset,
    output logic                   msu_start,
    output logic [MOD_LEN-1:0]     msu_sq_in,
    input  logic                   msu_valid,
    input  logic [SQ_OUT_BITS-1:0] msu_sq_out
);

    localparam int TMAX  = (RST_CYCLES > LAUNCH_CYCLES) ? RST_CYCLES : LAUNCH_CYCLES;
    localparam int TMR_W = $clog2(TMAX + 1);
    localparam int WD_W  = $clog2(WDOG_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RST_HOLD = 2'd1,
        LAUNCH   = 2'd2,
        RUN      = 2'd3
    } state_t;

    state_t              state, state_nx;
    logic [TMR_W-1:0]    timer, timer_nx;
    logic [WD_W-1:0]     wdog, wdog_nx;
    logic [ITER_W-1:0]   target;
    logic [ITER_W-1:0]   count_inc;

    logic accept;      // nonzero command taken in IDLE
    logic zero_cmd;    // zero-iteration command rejected in IDLE
    logic start_nx;    // msu_start for the next cycle
    logic complete;    // final valid seen in RUN
    logic wd_fire;     // watchdog expiry in RUN
    logic count_en;    // a valid pulse counted in RUN

    assign count_inc = iter_count + ITER_W'(1);

    // State, phase timer and watchdog registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            timer <= '0;
            wdog  <= '0;
        end else begin
            state <= state_nx;
            timer <= timer_nx;
            wdog  <= wdog_nx;
        end
    end

    // Next-state logic. In RUN, a completing valid outranks abort, abort
    // outranks the watchdog, and any valid clears the watchdog.
    always_comb begin
        state_nx = state;
        timer_nx = timer;
        wdog_nx  = wdog;
        accept   = 1'b0;
        zero_cmd = 1'b0;
        start_nx = 1'b0;
        complete = 1'b0;
        wd_fire  = 1'b0;
        count_en = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_start) begin
                    if (cmd_iters == '0) begin
                        zero_cmd = 1'b1;
                    end else begin
                        accept   = 1'b1;
                        state_nx = RST_HOLD;
                        timer_nx = TMR_W'(RST_CYCLES - 1);
                    end
                end
            end
            RST_HOLD: begin
                if (timer == '0) begin
                    state_nx = LAUNCH;
                    timer_nx = TMR_W'(LAUNCH_CYCLES - 1);
                    wdog_nx  = '0;
                    // A one-cycle launch window starts immediately.
                    start_nx = (LAUNCH_CYCLES == 1);
                end else begin
                    timer_nx = timer - TMR_W'(1);
                end
            end
            LAUNCH: begin
                // Start is raised for the last launch cycle; the watchdog
                // measures from that pulse.
                start_nx = (timer == TMR_W'(1));
                wdog_nx  = start_nx ? '0 : wdog + WD_W'(1);
                if (timer == '0) begin
                    state_nx = RUN;
                end else begin
                    timer_nx = timer - TMR_W'(1);
                end
            end
            RUN: begin
                count_en = msu_valid;
                wdog_nx  = msu_valid ? '0 : wdog + WD_W'(1);
                if (msu_valid && count_inc == target) begin
                    complete = 1'b1;
                    state_nx = IDLE;
                end else if (cmd_abort) begin
                    state_nx = IDLE;
                end else if (!msu_valid && wdog == WD_W'(WDOG_CYCLES - 1)) begin
                    wd_fire  = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Registered outputs and run datapath.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            iter_count   <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            msu_reset    <= 1'b1;
            msu_start    <= 1'b0;
            msu_sq_in    <= '0;
            target       <= '0;
        end else begin
            busy      <= (state_nx != IDLE);
            msu_reset <= (state_nx == IDLE) || (state_nx == RST_HOLD);
            done      <= complete;
            error     <= zero_cmd || wd_fire;
            msu_start <= start_nx;
            if (accept) begin
                msu_sq_in    <= cmd_sq_in;
                target       <= cmd_iters;
                iter_count   <= '0;
                result_valid <= 1'b0;
            end
            if (count_en) begin
                iter_count <= count_inc;
            end
            if (complete) begin
                result       <= msu_sq_out;
                result_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_modsq_iter_ctrl.sv
// Directed bench for modsq_iter_ctrl with a small MSU stub that pulses
// valid every 10 cycles and drives sq_out with the iteration number.
module tb_modsq_iter_ctrl;

    localparam int MOD_LEN     = 1024;
    localparam int SQB         = (1024 / 16 + 2) * 16 * 2;
    localparam int ITER_W      = 64;
    localparam int RSTC        = 4;
    localparam int LAUNCHC     = 4;
    localparam int WDOGC       = 32;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               cmd_start = 1'b0;
    logic [MOD_LEN-1:0] cmd_sq_in = '0;
    logic [ITER_W-1:0]  cmd_iters = '0;
    logic               cmd_abort;
    logic               tb_abort = 1'b0;
    logic               stub_abort = 1'b0;
    logic               busy, done, error, result_valid, msu_reset, msu_start;
    logic [ITER_W-1:0]  iter_count;
    logic [SQB-1:0]     result;
    logic [MOD_LEN-1:0] msu_sq_in;
    logic               msu_valid = 1'b0;
    logic [SQB-1:0]     msu_sq_out = '0;

    assign cmd_abort = tb_abort | stub_abort;

    modsq_iter_ctrl #(
        .MOD_LEN(MOD_LEN), .WORD_LEN(16), .REDUNDANT_ELEMENTS(2),
        .ITER_W(ITER_W), .RST_CYCLES(RSTC), .LAUNCH_CYCLES(LAUNCHC),
        .WDOG_CYCLES(WDOGC)
    ) dut (
        .clk(clk), .reset(reset), .cmd_start(cmd_start), .cmd_sq_in(cmd_sq_in),
        .cmd_iters(cmd_iters), .cmd_abort(cmd_abort), .busy(busy), .done(done),
        .error(error), .iter_count(iter_count), .result(result),
        .result_valid(result_valid), .msu_reset(msu_reset), .msu_start(msu_start),
        .msu_sq_in(msu_sq_in), .msu_valid(msu_valid), .msu_sq_out(msu_sq_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Event monitor: counts pulses and remembers the edge they followed.
    int   done_n = 0, err_n = 0, start_n = 0;
    int   done_cyc = -1, err_cyc = -1, start_cyc = -1, idle_cyc = -1;
    logic done_rst = 1'b0, done_busy = 1'b0;
    logic prev_busy = 1'b0;
    always @(negedge clk) begin
        if (done)      begin done_n++; done_cyc = cyc; done_rst = msu_reset; done_busy = busy; end
        if (error)     begin err_n++;  err_cyc = cyc; end
        if (msu_start) begin start_n++; start_cyc = cyc; end
        if (prev_busy && !busy) idle_cyc = cyc;
        prev_busy = busy;
    end

    // MSU stub: arms on msu_start, valid every 10 cycles up to stub_stop,
    // optionally raises abort with (or one cycle after) valid number abort_n.
    int stub_stop = 0, stub_abort_n = 0;
    bit stub_abort_same = 1'b0;
    int stub_cnt = 0, stub_tmr = 0, last_valid_edge = -1, abort_edge = -1;
    bit armed = 1'b0, abort_pend = 1'b0;
    always @(negedge clk) begin
        msu_valid  = 1'b0;
        stub_abort = 1'b0;
        if (msu_reset) begin
            armed = 1'b0; stub_cnt = 0; stub_tmr = 0; abort_pend = 1'b0;
        end else begin
            if (abort_pend) begin
                stub_abort = 1'b1; abort_pend = 1'b0; abort_edge = cyc + 1;
            end
            if (msu_start) begin
                armed = 1'b1; stub_tmr = 0;
            end else if (armed && stub_cnt < stub_stop) begin
                stub_tmr++;
                if (stub_tmr == 10) begin
                    stub_tmr = 0;
                    stub_cnt++;
                    msu_valid  = 1'b1;
                    msu_sq_out = SQB'(stub_cnt);
                    last_valid_edge = cyc + 1;
                    if (stub_cnt == stub_abort_n) begin
                        if (stub_abort_same) begin
                            stub_abort = 1'b1; abort_edge = cyc + 1;
                        end else begin
                            abort_pend = 1'b1;
                        end
                    end
                end
            end
        end
    end

    typedef struct {
        logic [15:0] sq;
        logic [63:0] iters;
        int          stop;
        int          abort_n;
        bit          abort_same;
        bit          wd;
        int          exp_done;
        int          exp_err;
        logic [63:0] exp_ic;
        bit          exp_rv;
        int          exp_res;
        logic [15:0] exp_sqin;
    } vec_t;

    vec_t vecs[6];

    task automatic run_row(input vec_t v, input int idx);
        int d0, e0, s0, k, n;
        string tag;
        tag = $sformatf("row%0d", idx);
        d0 = done_n; e0 = err_n; s0 = start_n;
        stub_stop = v.stop; stub_abort_n = v.abort_n; stub_abort_same = v.abort_same;
        @(negedge clk);
        cmd_start = 1'b1; cmd_sq_in = MOD_LEN'(v.sq); cmd_iters = v.iters;
        k = cyc + 1;
        @(negedge clk);
        cmd_start = 1'b0; cmd_sq_in = '1; cmd_iters = '1;
        n = 0;
        while (busy && n < 3000) begin @(negedge clk); n++; end
        if (n >= 3000) begin
            tests++; fails++;
            $display("FAIL %s timeout: busy still 1 after %0d cycles", tag, n);
        end
        repeat (2) @(negedge clk);
        chk({tag, " done_cnt"},  64'(done_n - d0), 64'(v.exp_done));
        chk({tag, " err_cnt"},   64'(err_n - e0), 64'(v.exp_err));
        chk({tag, " start_cnt"}, 64'(start_n - s0), (v.iters != 0) ? 64'd1 : 64'd0);
        chk({tag, " iter_count"}, iter_count, v.exp_ic);
        chk({tag, " result_valid"}, 64'(result_valid), 64'(v.exp_rv));
        chk({tag, " msu_sq_in"}, msu_sq_in[63:0], 64'(v.exp_sqin));
        chk({tag, " busy"}, 64'(busy), 64'd0);
        chk({tag, " msu_reset"}, 64'(msu_reset), 64'd1);
        if (v.exp_rv) begin
            chk({tag, " result"}, result[63:0], 64'(v.exp_res));
            chk({tag, " result_hi"}, 64'(|result[SQB-1:64]), 64'd0);
        end
        if (v.iters != 0)
            chk({tag, " start_time"}, 64'(start_cyc), 64'(k + RSTC + LAUNCHC - 1));
        if (v.exp_done != 0) begin
            chk({tag, " done_time"}, 64'(done_cyc), 64'(last_valid_edge));
            chk({tag, " done_msu_reset"}, 64'(done_rst), 64'd1);
            chk({tag, " done_busy"}, 64'(done_busy), 64'd0);
        end
        if (v.iters == 0)
            chk({tag, " zero_err_time"}, 64'(err_cyc), 64'(k));
        if (v.wd)
            chk({tag, " wdog_time"}, 64'(err_cyc), 64'(last_valid_edge + WDOGC));
        if (v.abort_n != 0 && !v.abort_same)
            chk({tag, " abort_time"}, 64'(idle_cyc), 64'(abort_edge));
    endtask

    initial begin
        int d0, e0, s0, n;
        //          sq      iters stop abn same wd  done err ic   rv res sqin
        vecs[0] = '{16'h3,   5,   100, 0,  0,   0,  1,   0,  5,   1, 5,  16'h3};
        vecs[1] = '{16'h77,  0,   100, 0,  0,   0,  0,   1,  5,   1, 5,  16'h3};
        vecs[2] = '{16'h44,  100, 100, 3,  0,   0,  0,   0,  3,   0, 0,  16'h44};
        vecs[3] = '{16'h55,  3,   100, 3,  1,   0,  1,   0,  3,   1, 3,  16'h55};
        vecs[4] = '{16'h66,  100, 2,   0,  0,   1,  0,   1,  2,   0, 0,  16'h66};
        vecs[5] = '{16'hABC, 1,   100, 0,  0,   0,  1,   0,  1,   1, 1,  16'hABC};

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst msu_reset", 64'(msu_reset), 64'd1);
        chk("rst iter_count", iter_count, 64'd0);
        chk("rst result", 64'(|result), 64'd0);
        chk("rst result_valid", 64'(result_valid), 64'd0);
        chk("rst msu_sq_in", 64'(|msu_sq_in), 64'd0);
        chk("rst pulses", 64'({done, error, msu_start}), 64'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) run_row(vecs[i], i);

        // Ignored mid-run command, then asynchronous reset mid-RUN.
        d0 = done_n; e0 = err_n; s0 = start_n;
        stub_stop = 100; stub_abort_n = 0; stub_abort_same = 1'b0;
        @(negedge clk);
        cmd_start = 1'b1; cmd_sq_in = MOD_LEN'(16'h11); cmd_iters = 64'd100;
        @(negedge clk);
        cmd_start = 1'b0;
        repeat (30) @(negedge clk);
        cmd_start = 1'b1; cmd_sq_in = MOD_LEN'(16'h22); cmd_iters = 64'd7;
        @(negedge clk);
        cmd_start = 1'b0;
        repeat (5) @(negedge clk);
        chk("ign msu_sq_in", msu_sq_in[63:0], 64'h11);
        chk("ign busy", 64'(busy), 64'd1);
        chk("ign start_cnt", 64'(start_n - s0), 64'd1);
        n = 0;
        while (iter_count < 3 && n < 200) begin @(negedge clk); n++; end
        chk("ign iter_count", iter_count, 64'd3);
        chk("pre-reset msu_reset", 64'(msu_reset), 64'd0);
        #1 reset = 1'b1;
        #1;
        chk("arst busy", 64'(busy), 64'd0);
        chk("arst msu_reset", 64'(msu_reset), 64'd1);
        chk("arst iter_count", iter_count, 64'd0);
        chk("arst result", 64'(|result), 64'd0);
        chk("arst result_valid", 64'(result_valid), 64'd0);
        chk("arst msu_sq_in", 64'(|msu_sq_in), 64'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("arst no_done", 64'(done_n - d0), 64'd0);
        chk("arst no_err", 64'(err_n - e0), 64'd0);
        chk("arst idle", 64'({busy, msu_reset}), 64'b01);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/modsq_iter_ctrl.md
# modsq_iter_ctrl

Run controller for the modular squaring unit (MSU) wrapper. It accepts a run command carrying a starting value and an iteration count, and holds the MSU in reset between runs. Each run it pulses start, counts valid pulses, captures the coefficient output at the target iteration, and supervises the run with an abort and a stall watchdog. It sits between the host/control registers and the wrapper, in the wrapper's `clk` domain.

## Interface
- MOD_LEN, 1024, modulus width in bits
- WORD_LEN, 16, coefficient word width
- REDUNDANT_ELEMENTS, 2, extra redundant coefficients
- NUM_ELEMENTS, MOD_LEN/WORD_LEN+REDUNDANT_ELEMENTS, total coefficients
- SQ_OUT_BITS, NUM_ELEMENTS*WORD_LEN*2, width of the wrapper output bus
- ITER_W, 64, iteration counter width
- RST_CYCLES, 16, minimum msu_reset high time before a launch
- LAUNCH_CYCLES, 16, wait after msu_reset falls before the msu_start pulse
- WDOG_CYCLES, 4096, maximum cycles without msu_valid in RUN before error

Ports:
- clk  in  1  system clock; single clock domain
- reset  in  1  asynchronous, active-high
- cmd_start  in  1  run request; sampled only in IDLE
- cmd_sq_in  in  MOD_LEN  starting value; latched on accept
- cmd_iters  in  ITER_W  target iteration count; latched on accept
- cmd_abort  in  1  terminate the current run
- busy  out  1  run in progress
- done  out  1  1-cycle pulse on successful completion
- error  out  1  1-cycle pulse on zero-iteration command or watchdog expiry
- iter_count  out  ITER_W  number of valid pulses in the current or last run
- result  out  SQ_OUT_BITS  captured msu_sq_out at the target iteration
- result_valid  out  1  result holds a completed run; cleared on the next accept
- msu_reset  out  1  MSU wrapper reset
- msu_start  out  1  MSU wrapper start; 1-cycle pulse
- msu_sq_in  out  MOD_LEN  MSU wrapper sq_in; held stable during a run
- msu_valid  in  1  MSU wrapper valid pulse; one per completed squaring
- msu_sq_out  in  SQ_OUT_BITS  MSU wrapper sq_out

## Operation
- All outputs are registered.
- Reset values: state=IDLE and msu_reset=1. All other outputs are 0, including result, msu_sq_in and iter_count.
- msu_reset=1 in IDLE and RST_HOLD; msu_reset=0 in LAUNCH and RUN. The MSU is therefore always frozen between runs.

States:
- **IDLE**: busy=0.
  - cmd_start=1 with cmd_iters==0: pulse error and stay in IDLE. Nothing is latched.
  - cmd_start=1 with cmd_iters!=0: latch cmd_sq_in into msu_sq_in and cmd_iters into the target. Clear iter_count and result_valid, set busy, go to RST_HOLD.
  - cmd_abort is ignored in IDLE, including when it coincides with cmd_start.
- **RST_HOLD**: keeps msu_reset high for RST_CYCLES cycles, counted down by a timer, then goes to LAUNCH.
- **LAUNCH**: waits LAUNCH_CYCLES cycles with msu_reset low, covering the wrapper's reset synchroniser. On the last cycle it drives msu_start=1 for one cycle and goes to RUN with the watchdog cleared.
- **RUN**:
  - Each msu_valid increments iter_count and clears the watchdog.
  - On msu_valid with iter_count+1==target: capture msu_sq_out into result, set result_valid, pulse done, go to IDLE.
  - The watchdog increments on every RUN cycle without msu_valid. On reaching WDOG_CYCLES: pulse error, go to IDLE. result_valid stays 0.
  - cmd_abort=1: go to IDLE with no done and no error. iter_count keeps its partial value.
- cmd_start outside IDLE is ignored and not queued. cmd_sq_in and cmd_iters are not sampled.
- msu_valid outside RUN is ignored.
- Arithmetic: iter_count and the target compare are unsigned ITER_W bits. The target is at least 1, so iter_count cannot wrap.

Simultaneous events in RUN:
- Final msu_valid together with cmd_abort: completion wins, so done and result are produced.
- msu_valid together with the watchdog reaching its limit: the valid wins and the watchdog clears.
- cmd_abort together with watchdog expiry: abort wins, with no error.

Asynchronous reset mid-run: every output immediately takes its reset value, msu_reset rises asynchronously, and no done or error is emitted.

## Timing
- cmd_start accepted at edge k:
  - busy=1 and msu_reset=1 from k+1.
  - msu_reset falls at k+RST_CYCLES+1.
  - msu_start=1 during cycle k+RST_CYCLES+LAUNCH_CYCLES.
- Final msu_valid sampled at edge m: at m+1, done=1 (one cycle), result_valid=1, result valid, busy=0 and msu_reset=1.
- Abort sampled at edge a: busy=0 and msu_reset=1 at a+1.
- Last valid (or the msu_start pulse) at edge w: watchdog error at w+WDOG_CYCLES+1 if no valid arrives.
- Zero-iteration command at edge k: error=1 at k+1, busy stays 0.
- Back-to-back runs: a new cmd_start is accepted on the first IDLE cycle after done.

## Test plan
Parameters for all scenarios: RST_CYCLES=4, LAUNCH_CYCLES=4, WDOG_CYCLES=32. The MSU stub pulses valid every 10 cycles and drives sq_out = iteration number.
- **Normal run**: cmd_iters=5, cmd_sq_in=0x3 -> msu_start 8 cycles after accept; done 1 cycle after the 5th valid; result=5; iter_count=5; msu_reset high the same cycle.
- **Zero iterations**: cmd_iters=0 -> error pulse at k+1; busy, msu_start, and done never assert.
- **Abort**: cmd_iters=100, abort after the 3rd valid -> busy=0 next cycle; iter_count=3; result_valid=0; no done or error. Abort on the same cycle as the final valid of cmd_iters=3 -> done, result=3.
- **Watchdog**: stub stops after 2 valids -> error exactly 33 cycles after the 2nd valid; iter_count=2; msu_reset=1.
- **Ignored command and async reset**: cmd_start with new cmd_sq_in mid-run -> msu_sq_in unchanged and no second run. Then assert reset mid-RUN -> all outputs 0 and msu_reset=1 without waiting for a clk edge.
